// File: rtl/ahb_lite_fir_mac_if.sv
//------------------------------------------------------------------------------
// Module   : ahb_lite_fir_mac_if
// Brief    : AHB-Lite slave-side bus bundle for the FIR MAC block.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ahb_lite_fir_mac_if #(
   parameter int DATA_W  = 16,
   parameter int HADDR_W = 8
);
   logic               hsel;
   logic [HADDR_W-1:0] haddr;
   logic [1:0]         htrans;
   logic               hwrite;
   logic [DATA_W-1:0]  hwdata;
   logic [DATA_W-1:0]  hrdata;
   logic               hready;
   logic               hresp;

   modport master (
      output hsel, haddr, htrans, hwrite, hwdata,
      input  hrdata, hready, hresp
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hwdata,
      output hrdata, hready, hresp
   );
endinterface

`default_nettype wire

// File: rtl/ahb_lite_fir_mac.sv
//------------------------------------------------------------------------------
// Module   : ahb_lite_fir_mac
// Brief    : AHB-Lite FIR filter, sequential single-multiplier MAC with
//            saturating output. Optional irq output via macro FIR_IRQ_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ahb_lite_fir_mac #(
   parameter int DATA_W   = 16,
   parameter int NUM_TAPS = 8,
   parameter int HADDR_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   ahb_lite_fir_mac_if.slave  bus
`ifdef FIR_IRQ_EN
   ,
   output logic               irq
`endif
);

   localparam int IDX_W = HADDR_W - 2;
   localparam int CNT_W = $clog2(NUM_TAPS);
   localparam int ACC_W = 2*DATA_W + CNT_W;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAC = 2'd1, S_DONE = 2'd2} state_t;

   state_t                    state_q, state_d;
   logic signed [DATA_W-1:0]  coef_q [NUM_TAPS];
   logic signed [DATA_W-1:0]  hist_q [NUM_TAPS];
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]          tap_q, tap_d;
   logic [DATA_W-1:0]         result_q, sample_q;
   logic                      busy_q, err_q, rv_q;
   logic                      dp_q, dwrite_q, err2_q;
   logic [IDX_W-1:0]          didx_q;

   logic                      w_capture, w_map, w_err, w_stall, w_wr, w_rd;
   logic                      is_status, is_result, is_sample, is_ctrl, is_coef;
   logic [31:0]               w_idx;
   logic [CNT_W-1:0]          w_k;
   logic signed [2*DATA_W-1:0] w_prod;
   logic signed [ACC_W-1:0]   w_shift;
   logic                      w_sat;
   logic [DATA_W-1:0]         w_sat_val, w_status;
   logic                      w_irq_bit;
   logic                      w_unused;

   assign w_unused  = ^bus.haddr[1:0];
   assign w_capture = bus.hsel && bus.htrans[1] && bus.hready;

   // Decode of the registered data-phase address
   assign w_idx     = 32'(didx_q);
   assign w_k       = didx_q[CNT_W-1:0] - CNT_W'(4);
   assign is_status = (w_idx == 32'd0);
   assign is_result = (w_idx == 32'd1);
   assign is_sample = (w_idx == 32'd2);
   assign is_ctrl   = (w_idx == 32'd3);
   assign is_coef   = (w_idx >= 32'd4) && (w_idx < 32'(4 + NUM_TAPS));
   assign w_map     = is_status | is_result | is_sample | is_ctrl | is_coef;

   assign w_err   = dp_q && (!w_map || (dwrite_q && (is_status || is_result)));
   assign w_stall = dp_q && dwrite_q && !w_err && busy_q;
   assign w_wr    = dp_q && dwrite_q && !w_err && !busy_q;
   assign w_rd    = dp_q && !dwrite_q && !w_err;

   assign bus.hready = !((w_err && !err2_q) || w_stall);
   assign bus.hresp  = w_err;

`ifdef FIR_IRQ_EN
   assign w_irq_bit = irq;
`else
   assign w_irq_bit = 1'b0;
`endif

   always_comb begin
      w_status      = '0;
      w_status[3:0] = {w_irq_bit, rv_q, err_q, busy_q};
   end

   always_comb begin
      bus.hrdata = '0;
      if (w_rd) begin
         if (is_status)      bus.hrdata = w_status;
         else if (is_result) bus.hrdata = result_q;
         else if (is_sample) bus.hrdata = sample_q;
         else if (is_coef)   bus.hrdata = coef_q[w_k];
      end
   end

   // Saturate when the bits above the result's sign bit disagree with it
   assign w_prod  = hist_q[tap_q] * coef_q[tap_q];
   assign w_shift = acc_q >>> (DATA_W-1);
   assign w_sat   = !((&w_shift[ACC_W-1:DATA_W-1]) || !(|w_shift[ACC_W-1:DATA_W-1]));
   always_comb begin
      w_sat_val = w_shift[DATA_W-1:0];
      if (w_sat) w_sat_val = {w_shift[ACC_W-1], {(DATA_W-1){~w_shift[ACC_W-1]}}};
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      tap_d   = tap_q;
      case (state_q)
         S_IDLE: begin
            if (w_wr && is_sample) begin
               state_d = S_MAC;
               acc_d   = '0;
               tap_d   = '0;
            end
         end
         S_MAC: begin
            acc_d = acc_q + ACC_W'(w_prod);
            if (tap_q == CNT_W'(NUM_TAPS-1)) state_d = S_DONE;
            else                             tap_d   = tap_q + 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         tap_q    <= '0;
         result_q <= '0;
         sample_q <= '0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         rv_q     <= 1'b0;
         dp_q     <= 1'b0;
         dwrite_q <= 1'b0;
         err2_q   <= 1'b0;
         didx_q   <= '0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            coef_q[k] <= '0;
            hist_q[k] <= '0;
         end
`ifdef FIR_IRQ_EN
         irq      <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         tap_q   <= tap_d;
         err2_q  <= w_err && !err2_q;
         if (bus.hready) dp_q <= w_capture;
         if (w_capture) begin
            didx_q   <= bus.haddr[HADDR_W-1:2];
            dwrite_q <= bus.hwrite;
         end
         if (w_wr && is_sample) begin
            sample_q <= bus.hwdata;
            for (int k = NUM_TAPS-1; k > 0; k--) hist_q[k] <= hist_q[k-1];
            hist_q[0] <= bus.hwdata;
            busy_q    <= 1'b1;
         end
         if (w_wr && is_coef) coef_q[w_k] <= bus.hwdata;
         if (state_q == S_DONE) begin
            result_q <= w_sat_val;
            rv_q     <= 1'b1;
            busy_q   <= 1'b0;
            if (w_sat) err_q <= 1'b1;
         end
         // Clear comes after the DONE update so it takes priority
         if (w_wr && is_ctrl && bus.hwdata[0]) begin
            for (int k = 0; k < NUM_TAPS; k++) hist_q[k] <= '0;
            err_q <= 1'b0;
            rv_q  <= 1'b0;
         end
`ifdef FIR_IRQ_EN
         if (w_rd && is_result)  irq <= 1'b0;
         if (state_q == S_DONE)  irq <= 1'b1;
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_fir_mac.sv
//------------------------------------------------------------------------------
// Module   : tb_ahb_lite_fir_mac
// Brief    : Directed self-checking bench for ahb_lite_fir_mac (4 taps, 16 bit).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ahb_lite_fir_mac;
   localparam int DW = 16;
   localparam int NT = 4;
   localparam int AW = 8;
`ifdef FIR_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   localparam logic [7:0] A_STATUS = 8'h00;
   localparam logic [7:0] A_RESULT = 8'h04;
   localparam logic [7:0] A_SAMPLE = 8'h08;
   localparam logic [7:0] A_CTRL   = 8'h0C;
   localparam logic [7:0] A_COEF   = 8'h10;
   localparam logic [7:0] A_BAD    = 8'h20;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ahb_lite_fir_mac_if #(.DATA_W(DW), .HADDR_W(AW)) bus ();
`ifdef FIR_IRQ_EN
   logic irq;
`endif

   ahb_lite_fir_mac #(.DATA_W(DW), .NUM_TAPS(NT), .HADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
`ifdef FIR_IRQ_EN
      ,
      .irq (irq)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Entered at a negedge with hready=1; returns at the negedge of the
   // completing data-phase cycle, so the next call pipelines behind it.
   task automatic xfer(input logic [7:0] addr, input logic wr, input logic [15:0] wdata,
                       output logic [15:0] rdata, output int stall,
                       output logic resp0, output logic resp1);
      bus.hsel   = 1'b1;
      bus.htrans = 2'd2;
      bus.haddr  = addr;
      bus.hwrite = wr;
      @(negedge clk);
      bus.hsel   = 1'b0;
      bus.htrans = 2'd0;
      bus.hwrite = 1'b0;
      if (wr) bus.hwdata = wdata;
      resp0 = bus.hresp;
      stall = 0;
      while (!bus.hready && stall < 200) begin
         stall++;
         @(negedge clk);
      end
      if (!bus.hready) check_eq("hready_timeout", 32'(bus.hready), 32'd1);
      resp1 = bus.hresp;
      rdata = bus.hrdata;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [15:0] d);
      logic [15:0] r; int s; logic a, b;
      xfer(addr, 1'b1, d, r, s, a, b);
   endtask

   task automatic rd(input logic [7:0] addr, output logic [15:0] d);
      int s; logic a, b;
      xfer(addr, 1'b0, 16'h0, d, s, a, b);
   endtask

   task automatic wait_idle();
      logic [15:0] st;
      int n = 0;
      do begin
         rd(A_STATUS, st);
         n++;
      end while (st[0] && n < 100);
      if (st[0]) check_eq("busy_timeout", 32'(st[0]), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] v, st;
      logic        r0, r1;
      int          s;
      logic [15:0] exp1 [4] = '{16'h0800, 16'h1000, 16'h1800, 16'h2000};

      rst        = 1'b1;
      bus.hsel   = 1'b0;
      bus.htrans = 2'd0;
      bus.haddr  = '0;
      bus.hwrite = 1'b0;
      bus.hwdata = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_hready", 32'(bus.hready), 32'd1);
      check_eq("rst_hresp",  32'(bus.hresp),  32'd0);
      check_eq("rst_hrdata", 32'(bus.hrdata), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      rd(A_STATUS, v); check_eq("rst_status", 32'(v), 32'h0);
      rd(A_RESULT, v); check_eq("rst_result", 32'(v), 32'h0);

      // Half-gain taps, constant input ramps the output
      for (int k = 0; k < NT; k++) wr(A_COEF + 8'(4*k), 16'h4000);
      rd(A_COEF + 8'h08, v); check_eq("coef2_rb", 32'(v), 32'h4000);
      for (int i = 0; i < 4; i++) begin
         wr(A_SAMPLE, 16'h1000);
         wait_idle();
         rd(A_RESULT, v); check_eq($sformatf("ramp_result%0d", i), 32'(v), 32'(exp1[i]));
         rd(A_STATUS, st);
         check_eq("ramp_err", 32'(st[1]), 32'd0);
         check_eq("ramp_rv",  32'(st[2]), 32'd1);
      end
      rd(A_SAMPLE, v); check_eq("sample_rb", 32'(v), 32'h1000);

      // Negative input: -1.0 * 0.5 = -0.5
      wr(A_CTRL, 16'h0001);
      for (int k = 1; k < NT; k++) wr(A_COEF + 8'(4*k), 16'h0000);
      wr(A_SAMPLE, 16'h8000);
      wait_idle();
      rd(A_RESULT, v); check_eq("neg_result", 32'(v), 32'hC000);

      // Positive saturation
      for (int k = 0; k < NT; k++) wr(A_COEF + 8'(4*k), 16'h7FFF);
      for (int i = 0; i < 4; i++) begin
         wr(A_SAMPLE, 16'h7FFF);
         wait_idle();
      end
      rd(A_STATUS, st);
      check_eq("sat_err",        32'(st[1]), 32'd1);
      check_eq("status_irq_bit", 32'(st[3]), 32'(IRQ_ON));
      rd(A_RESULT, v); check_eq("sat_result", 32'(v), 32'h7FFF);
      wr(A_CTRL, 16'h0001);
      rd(A_STATUS, st); check_eq("ctrl_clear", 32'(st[2:0]), 32'h0);

      // Error responses leave registers untouched
      xfer(A_RESULT, 1'b1, 16'h1234, v, s, r0, r1);
      check_eq("err_wr_result_stall", 32'(s), 32'd1);
      check_eq("err_wr_result_resp0", 32'(r0), 32'd1);
      check_eq("err_wr_result_resp1", 32'(r1), 32'd1);
      rd(A_RESULT, v); check_eq("err_result_kept", 32'(v), 32'h7FFF);
      xfer(A_BAD, 1'b1, 16'h1111, v, s, r0, r1);
      check_eq("err_bad_stall", 32'(s), 32'd1);
      check_eq("err_bad_resp",  32'({r0, r1}), 32'h3);
      xfer(A_BAD, 1'b0, 16'h0, v, s, r0, r1);
      check_eq("err_bad_rd_resp", 32'({r0, r1}), 32'h3);
      check_eq("err_bad_rdata",   32'(v), 32'h0);
      rd(A_COEF, v); check_eq("err_coef_kept", 32'(v), 32'h7FFF);

      // IDLE transfer with hsel is ignored
      bus.hsel = 1'b1; bus.htrans = 2'd0; bus.haddr = A_BAD;
      @(negedge clk);
      bus.hsel = 1'b0;
      check_eq("idle_ignored", 32'({bus.hready, bus.hresp}), 32'h2);

      // Back-to-back samples: second stalls until busy falls
      wr(A_SAMPLE, 16'h0100);
      xfer(A_SAMPLE, 1'b1, 16'h0100, v, s, r0, r1);
      check_eq("b2b_stall", 32'(s), 32'(NT + 1));
      xfer(A_STATUS, 1'b0, 16'h0, st, s, r0, r1);
      check_eq("busy_read_stall", 32'(s), 32'd0);
      check_eq("busy_read_bit0",  32'(st[0]), 32'd1);
      wait_idle();

      // Reset in the middle of MAC
      wr(A_CTRL, 16'h0001);
      wr(A_SAMPLE, 16'h1000);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rd(A_STATUS, v); check_eq("midrst_status", 32'(v), 32'h0);
      rd(A_RESULT, v); check_eq("midrst_result", 32'(v), 32'h0);
      wr(A_COEF, 16'h4000);
      wr(A_SAMPLE, 16'h1000);
      wait_idle();
      rd(A_RESULT, v); check_eq("midrst_new_result", 32'(v), 32'h0800);

`ifdef FIR_IRQ_EN
      wr(A_SAMPLE, 16'h1000);
      wait_idle();
      check_eq("irq_set", 32'(irq), 32'd1);
      rd(A_RESULT, v);
      @(negedge clk);
      check_eq("irq_cleared", 32'(irq), 32'd0);
      wr(A_SAMPLE, 16'h1000);
      for (int i = 0; i < NT; i++) rd(A_STATUS, st);
      rd(A_RESULT, v);
      @(negedge clk);
      check_eq("irq_set_wins", 32'(irq), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

`default_nettype wire
